// File: rtl/mtr_pkg.sv
// Shared types and constants for the motor PWM drive.
package mtr_pkg;

  localparam int unsigned PWM_W = 11;

  typedef logic [PWM_W-1:0] duty_t;

  localparam duty_t DUTY_MID = 11'h400;
  localparam int    SPD_MAX  = 1023;
  localparam int    SPD_MIN  = -1024;

  // Clamp a signed 12-bit speed to the PWM range, then offset so zero speed is 50% duty.
  function automatic duty_t sat_duty(input logic [11:0] spd);
    int spd_i;
    spd_i = int'($signed(spd));
    if (spd_i > SPD_MAX) begin
      spd_i = SPD_MAX;
    end else if (spd_i < SPD_MIN) begin
      spd_i = SPD_MIN;
    end
    return duty_t'(spd_i + int'(DUTY_MID));
  endfunction

endpackage

// File: rtl/pwm_deadband.sv
// Complementary bridge driver: both sides low for DEAD_CYC cycles after every raw edge.
module pwm_deadband #(
  parameter int unsigned DEAD_CYC = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic kill,
  output logic PWM1,
  output logic PWM2
);

  localparam int unsigned DCNT_W = 8;

  logic              raw_q;
  logic [DCNT_W-1:0] dcnt;
  logic [DCNT_W-1:0] dcnt_nxt_c;
  logic              pwm1_nxt_c;
  logic              pwm2_nxt_c;

  // Dead counter restarts on a raw edge; outputs are driven one cycle ahead of dcnt reaching DEAD_CYC.
  always_comb begin
    dcnt_nxt_c = dcnt;
    pwm1_nxt_c = 1'b0;
    pwm2_nxt_c = 1'b0;
    if (raw != raw_q) begin
      dcnt_nxt_c = '0;
    end else if (dcnt != DCNT_W'(DEAD_CYC)) begin
      dcnt_nxt_c = dcnt + DCNT_W'(1);
    end
    if (!kill && (dcnt_nxt_c == DCNT_W'(DEAD_CYC))) begin
      pwm1_nxt_c = raw;
      pwm2_nxt_c = ~raw;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= 1'b0;
      dcnt  <= '0;
      PWM1  <= 1'b0;
      PWM2  <= 1'b0;
    end else begin
      raw_q <= raw;
      dcnt  <= dcnt_nxt_c;
      PWM1  <= pwm1_nxt_c;
      PWM2  <= pwm2_nxt_c;
    end
  end

endmodule

// File: rtl/mtr_pwm_drv.sv
// Motor PWM back end: period counter, speed saturation, shadowed duty, dead-banded
// H-bridge drive per side. Over-current shutdown is built when MTR_OVR_I_SHTDWN_EN is defined.
module mtr_pwm_drv
  import mtr_pkg::*;
#(
  parameter int unsigned DEAD_CYC  = 32,
  parameter int unsigned BLANK_CYC = 128,
  parameter int unsigned OVR_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        OVR_I_lft,
  input  logic        OVR_I_rght,
  output logic        lft_PWM1,
  output logic        lft_PWM2,
  output logic        rght_PWM1,
  output logic        rght_PWM2,
  output logic        PWM_synch,
  output logic        OVR_I_shtdwn
);

  logic [PWM_W-1:0] cnt;
  logic             synch_c;
  duty_t            lft_duty_q;
  duty_t            rght_duty_q;
  logic             lft_raw_c;
  logic             rght_raw_c;
  logic             shtdwn_nxt_c;

  assign synch_c    = (cnt == '1);
  assign lft_raw_c  = (cnt < lft_duty_q);
  assign rght_raw_c = (cnt < rght_duty_q);

  // Free-running period counter and period-end pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      PWM_synch <= 1'b0;
    end else begin
      cnt       <= cnt + PWM_W'(1);
      PWM_synch <= (cnt == PWM_W'(2046));
    end
  end

  // Duty shadows take new speeds only at the period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_duty_q  <= DUTY_MID;
      rght_duty_q <= DUTY_MID;
    end else if (synch_c) begin
      lft_duty_q  <= sat_duty(lft_spd);
      rght_duty_q <= sat_duty(rght_spd);
    end
  end

`ifdef MTR_OVR_I_SHTDWN_EN
  logic       seen_lft;
  logic       seen_rght;
  logic [3:0] ovr_cnt;
  logic [3:0] ovr_cnt_inc_c;
  logic       blank_ok_c;

  assign blank_ok_c = (cnt >= PWM_W'(BLANK_CYC));

  // Shutdown is decided combinationally so the bridge drops on the same cycle the flag rises.
  always_comb begin
    ovr_cnt_inc_c = ovr_cnt + 4'd1;
    shtdwn_nxt_c  = OVR_I_shtdwn;
    if (synch_c && (seen_lft || seen_rght) && (ovr_cnt_inc_c == 4'(OVR_LIMIT))) begin
      shtdwn_nxt_c = 1'b1;
    end
  end

  // Per-period over-current capture, consecutive-period count and sticky shutdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_lft     <= 1'b0;
      seen_rght    <= 1'b0;
      ovr_cnt      <= '0;
      OVR_I_shtdwn <= 1'b0;
    end else begin
      OVR_I_shtdwn <= shtdwn_nxt_c;
      if (synch_c) begin
        seen_lft  <= 1'b0;
        seen_rght <= 1'b0;
        ovr_cnt   <= (seen_lft || seen_rght) ? ovr_cnt_inc_c : 4'd0;
      end else begin
        if (OVR_I_lft && lft_PWM1 && blank_ok_c) begin
          seen_lft <= 1'b1;
        end
        if (OVR_I_rght && rght_PWM1 && blank_ok_c) begin
          seen_rght <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_ovr_c;

  assign shtdwn_nxt_c = 1'b0;
  assign OVR_I_shtdwn = 1'b0;
  assign unused_ovr_c = &{1'b0, OVR_I_lft, OVR_I_rght, PWM_W'(BLANK_CYC), 4'(OVR_LIMIT)};
`endif

  pwm_deadband #(
    .DEAD_CYC (DEAD_CYC)
  ) u_lft_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (lft_raw_c),
    .kill  (shtdwn_nxt_c),
    .PWM1  (lft_PWM1),
    .PWM2  (lft_PWM2)
  );

  pwm_deadband #(
    .DEAD_CYC (DEAD_CYC)
  ) u_rght_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (rght_raw_c),
    .kill  (shtdwn_nxt_c),
    .PWM1  (rght_PWM1),
    .PWM2  (rght_PWM2)
  );

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Directed bench for mtr_pwm_drv; over-current scenarios run when MTR_OVR_I_SHTDWN_EN is defined.
module tb_mtr_pwm_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        OVR_I_lft;
  logic        OVR_I_rght;
  logic        lft_PWM1;
  logic        lft_PWM2;
  logic        rght_PWM1;
  logic        rght_PWM2;
  logic        PWM_synch;
  logic        OVR_I_shtdwn;

  int n_vec = 0;
  int n_err = 0;

  int m_l1, m_l2, m_r1, m_r2, m_both, m_syn, m_syn_last, m_shd, m_r1_last;

  mtr_pwm_drv u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .OVR_I_lft    (OVR_I_lft),
    .OVR_I_rght   (OVR_I_rght),
    .lft_PWM1     (lft_PWM1),
    .lft_PWM2     (lft_PWM2),
    .rght_PWM1    (rght_PWM1),
    .rght_PWM2    (rght_PWM2),
    .PWM_synch    (PWM_synch),
    .OVR_I_shtdwn (OVR_I_shtdwn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Count negedges until PWM_synch is seen; -1 on timeout.
  task automatic wait_synch(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!PWM_synch && n < 4096);
    if (!PWM_synch) n = -1;
  endtask

  // One full period starting right after a PWM_synch sample; index i equals cnt.
  task automatic measure(input int ovr_at, input int chg_at, input logic [11:0] chg_val);
    m_l1 = 0; m_l2 = 0; m_r1 = 0; m_r2 = 0; m_both = 0;
    m_syn = 0; m_syn_last = -1; m_shd = 0; m_r1_last = -1;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      OVR_I_lft = (i == ovr_at);
      if (i == chg_at) rght_spd = chg_val;
      m_l1 += int'(lft_PWM1);
      m_l2 += int'(lft_PWM2);
      m_r1 += int'(rght_PWM1);
      m_r2 += int'(rght_PWM2);
      m_shd += int'(OVR_I_shtdwn);
      if ((lft_PWM1 && lft_PWM2) || (rght_PWM1 && rght_PWM2)) m_both++;
      if (PWM_synch) begin
        m_syn++;
        m_syn_last = i;
      end
      if (rght_PWM1) m_r1_last = i;
    end
  endtask

  task automatic check_period(input string tag, input int l1, input int l2, input int r1, input int r2);
    chk({tag, ".l1"}, m_l1, l1);
    chk({tag, ".l2"}, m_l2, l2);
    chk({tag, ".r1"}, m_r1, r1);
    chk({tag, ".r2"}, m_r2, r2);
    chk({tag, ".both"}, m_both, 0);
    chk({tag, ".syn"}, m_syn, 1);
    chk({tag, ".syn_at"}, m_syn_last, 2047);
  endtask

  initial begin
    int n;
    int shd_sum;
    rst_n      = 1'b0;
    lft_spd    = 12'h000;
    rght_spd   = 12'h000;
    OVR_I_lft  = 1'b0;
    OVR_I_rght = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", int'({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, OVR_I_shtdwn}), 0);
    rst_n = 1'b1;
    wait_synch(n);
    chk("synch_lat", n, 2047);

    // Zero speed: 50% duty with dead band on both edges.
    for (int p = 0; p < 3; p++) begin
      measure(-1, -1, 12'h000);
      check_period("zero", 992, 992, 992, 992);
      chk("zero.shd", m_shd, 0);
    end

    // Positive saturation.
    lft_spd = 12'h7FF;
    measure(-1, -1, 12'h000);
    check_period("max_t", 2015, 1, 992, 992);
    measure(-1, -1, 12'h000);
    check_period("max", 2015, 0, 992, 992);

    // Negative saturation: duty 0.
    lft_spd = 12'h800;
    measure(-1, -1, 12'h000);
    check_period("min_t", 0, 2016, 992, 992);
    measure(-1, -1, 12'h000);
    check_period("min", 0, 2048, 992, 992);

    // Mid-period speed change waits for the next period.
    measure(-1, 500, 12'h100);
    check_period("shadow_old", 0, 2048, 992, 992);
    measure(-1, -1, 12'h000);
    check_period("shadow_new", 0, 2048, 1248, 736);
    chk("shadow_r1_last", m_r1_last, 1280);

    // Asynchronous reset in the middle of a period.
    lft_spd  = 12'h000;
    rght_spd = 12'h000;
    repeat (1001) @(negedge clk);
    chk("pre_rst_l1", int'(lft_PWM1), 1);
    chk("pre_rst_r1", int'(rght_PWM1), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", int'({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, OVR_I_shtdwn}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_synch(n);
    chk("rst_restart", n, 2047);

`ifdef MTR_OVR_I_SHTDWN_EN
    // Over-current inside the blanking window is ignored.
    shd_sum = 0;
    for (int p = 0; p < 8; p++) begin
      measure(100, -1, 12'h000);
      shd_sum += m_shd;
    end
    check_period("blank", 992, 992, 992, 992);
    chk("blank.shd", shd_sum, 0);

    // Seven bad periods then a clean one reset the run.
    shd_sum = 0;
    for (int p = 0; p < 7; p++) begin
      measure(600, -1, 12'h000);
      shd_sum += m_shd;
    end
    measure(-1, -1, 12'h000);
    shd_sum += m_shd;
    chk("seven.shd", shd_sum, 0);

    // Eight consecutive bad periods trip the shutdown.
    shd_sum = 0;
    for (int p = 0; p < 8; p++) begin
      measure(600, -1, 12'h000);
      shd_sum += m_shd;
    end
    chk("eight.pre_shd", shd_sum, 0);
    check_period("eight_last", 992, 992, 992, 992);
    measure(-1, -1, 12'h000);
    check_period("shut", 0, 0, 0, 0);
    chk("shut.shd", m_shd, 2048);

    // Only reset clears shutdown.
    rst_n = 1'b0;
    #1;
    chk("shut_rst_outs", int'({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, OVR_I_shtdwn}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_synch(n);
    chk("shut_rst_lat", n, 2047);
    measure(-1, -1, 12'h000);
    check_period("post_shut", 992, 992, 992, 992);
    chk("post_shut.shd", m_shd, 0);
`else
    // Monitor absent: over-current inputs have no effect.
    OVR_I_rght = 1'b1;
    shd_sum = 0;
    for (int p = 0; p < 2; p++) begin
      measure(600, -1, 12'h000);
      shd_sum += m_shd;
      check_period("no_mon", 992, 992, 992, 992);
    end
    chk("no_mon.shd", shd_sum, 0);
    OVR_I_rght = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
